spike_event_fifo: RTL and testbench

//  Downstream consumer of the Izhikevich neuron's spike output. Detects spike rising edges,

---
 rtl/spike_event_fifo.sv | 118 +++++++++++
 tb/tb_spike_event_fifo.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// Spike rising-edge detector with free-running timestamp and an event FIFO on a valid/ready stream.
// Optional inter-spike-interval field per entry is enabled by defining SPIKE_FIFO_ISI_EN.
module spike_event_fifo #(
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          spike,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TS_W-1:0]               out_ts,
`ifdef SPIKE_FIFO_ISI_EN
  output logic [TS_W-1:0]               out_isi,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef SPIKE_FIFO_ISI_EN
  localparam int EW = 2 * TS_W;
`else
  localparam int EW = TS_W;
`endif

  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                  spike_q;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         wdata, rdata;
  logic                  evt, full, pop, push, drop;

  always_comb begin
    evt        = spike & ~spike_q & enable;
    full       = (count_q == DEPTH_C);
    pop        = (count_q != '0) & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push       = evt & (~full | pop);
    drop       = evt & full & ~pop;
    ts_d       = enable ? ts_q + 1'b1 : ts_q;
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    overflow_d = overflow_q | drop;
    drop_d     = drop ? sat_inc_drop(drop_q) : drop_q;
  end

`ifdef SPIKE_FIFO_ISI_EN
  function automatic logic [TS_W-1:0] sat_inc_ts(input logic [TS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [TS_W-1:0] isi_q, isi_d;

  // An accepted event restarts the interval; its own cycle already counts as one enabled cycle.
  always_comb begin
    isi_d = enable ? sat_inc_ts(isi_q) : isi_q;
    if (push) isi_d = {{(TS_W-1){1'b0}}, 1'b1};
    wdata = {isi_q, ts_q};
  end

  always_ff @(posedge clk) begin
    if (reset) isi_q <= '0;
    else       isi_q <= isi_d;
  end

  assign out_isi = out_valid ? rdata[EW-1:TS_W] : '0;
`else
  assign wdata = ts_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_q    <= 1'b0;
      ts_q       <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      spike_q    <= spike;
      ts_q       <= ts_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign rdata      = mem_q[rptr_q];
  assign out_valid  = (count_q != '0);
  assign out_ts     = out_valid ? rdata[TS_W-1:0] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spike_event_fifo.sv
// Bench for spike_event_fifo: directed scenarios plus randomized traffic against a queue-based model.
module tb_spike_event_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        spike = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_ts;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;
`ifdef SPIKE_FIFO_ISI_EN
  logic [15:0] out_isi;
`endif

  int checks = 0;
  int errors = 0;

  spike_event_fifo #(.TS_W(16), .FIFO_DEPTH(8), .DROP_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .spike(spike),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
`ifdef SPIKE_FIFO_ISI_EN
    .out_isi(out_isi),
`endif
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of buffered events plus bookkeeping of the behavioural rules.
  logic [15:0] mq[$];
  logic [15:0] mi[$];
  logic [15:0] mts;
  logic        mprev;
  logic        movf;
  logic [7:0]  mdrop;
  int          mes;

  function automatic void model_step();
    bit ev, pop, full;
    if (reset) begin
      mq.delete(); mi.delete();
      mts = '0; mprev = 1'b0; movf = 1'b0; mdrop = '0; mes = 0;
      return;
    end
    pop  = (mq.size() != 0) && out_ready;
    full = (mq.size() == 8);
    ev   = spike && !mprev && enable;
    if (pop) begin
      void'(mq.pop_front());
      void'(mi.pop_front());
    end
    if (ev) begin
      if (!full || pop) begin
        mq.push_back(mts);
        mi.push_back(mes > 65535 ? 16'hFFFF : 16'(mes));
        mes = 0;
      end else begin
        movf = 1'b1;
        if (mdrop != 8'hFF) mdrop = mdrop + 8'd1;
      end
    end
    if (enable) begin
      mts = mts + 16'd1;
      mes = mes + 1;
    end
    mprev = spike;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; spike = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0 || out_ts !== 16'd0) begin
      errors++;
      $display("FAIL reset_fifo valid=%0b count=%0d ts=%0d expected 0/0/0", out_valid, fifo_count, out_ts);
    end
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop ovf=%0b drop=%0d expected 0/0", overflow, drop_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    spike = 1'b1; tick(); spike = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ts !== 16'd5 || fifo_count !== 4'd1) begin
      errors++;
      $display("FAIL single_event valid=%0b ts=%0d count=%0d expected 1/5/1", out_valid, out_ts, fifo_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL single_drain valid=%0b count=%0d expected 0/0", out_valid, fifo_count);
    end
  endtask

  task automatic test_held();
    int n;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    n = $urandom_range(3, 20);
    repeat (n) tick();
    spike = 1'b1;
    repeat (10) tick();
    spike = 1'b0;
    tick();
    checks++;
    if (fifo_count !== 4'd1 || out_ts !== 16'(n)) begin
      errors++;
      $display("FAIL held_spike count=%0d ts=%0d expected 1/%0d", fifo_count, out_ts, n);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike = 1'b1; tick(); spike = 1'b0; tick();
    end
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      errors++;
      $display("FAIL overflow_state count=%0d ovf=%0b drop=%0d expected 8/1/2", fifo_count, overflow, drop_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_ts !== 16'(2 * i)) begin
        errors++;
        $display("FAIL overflow_drain[%0d] valid=%0b ts=%0d expected 1/%0d", i, out_valid, out_ts, 2 * i);
      end
      tick();
    end
    checks++;
    if (fifo_count !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky count=%0d ovf=%0b expected 0/1", fifo_count, overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      spike = 1'b1; tick(); spike = 1'b0; tick();
    end
    spike = 1'b1; out_ready = 1'b1;
    tick();
    spike = 1'b0; out_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL full_pop_push count=%0d ovf=%0b drop=%0d expected 8/0/0", fifo_count, overflow, drop_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_ts !== 16'(2 * i + 2)) begin
        errors++;
        $display("FAIL full_pop_order[%0d] valid=%0b ts=%0d expected 1/%0d", i, out_valid, out_ts, 2 * i + 2);
      end
      tick();
    end
  endtask

  task automatic test_enable_wrap();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike = (i % 2) != 0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
        errors++;
        $display("FAIL enable_low_event[%0d] valid=%0b count=%0d expected 0/0", i, out_valid, fifo_count);
      end
    end
    enable = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_rise_high valid=%0b expected 0", out_valid);
    end
    spike = 1'b0; tick();
    spike = 1'b1; tick(); spike = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ts !== 16'd7) begin
      errors++;
      $display("FAIL ts_frozen valid=%0b ts=%0d expected 1/7", out_valid, out_ts);
    end
    while (mts != 16'hFFFF) tick();
    spike = 1'b1; tick();
    checks++;
    if (out_valid !== 1'b1 || out_ts !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_top valid=%0b ts=%0h expected 1/ffff", out_valid, out_ts);
    end
    spike = 1'b0; enable = 1'b0; tick();
    spike = 1'b1; enable = 1'b1; tick(); spike = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ts !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero valid=%0b ts=%0h expected 1/0000", out_valid, out_ts);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    repeat (3) begin
      spike = 1'b1; tick(); spike = 1'b0; tick();
    end
    checks++;
    if (fifo_count !== 4'd3) begin
      errors++;
      $display("FAIL mid_fill count=%0d expected 3", fifo_count);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset valid=%0b count=%0d expected 0/0", out_valid, fifo_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      enable    = ($urandom_range(0, 9) < 8);
      spike     = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 9) < 3);
      tick();
      checks++;
      if (out_valid !== (mq.size() != 0) || fifo_count !== 4'(mq.size()) ||
          (mq.size() != 0 && out_ts !== mq[0]) || overflow !== movf || drop_count !== mdrop) begin
        errors++;
        $display("FAIL random[%0d] valid=%0b count=%0d ts=%0d ovf=%0b drop=%0d expected count=%0d ts=%0d ovf=%0b drop=%0d",
                 c, out_valid, fifo_count, out_ts, overflow, drop_count,
                 mq.size(), (mq.size() != 0) ? mq[0] : 16'd0, movf, mdrop);
      end
`ifdef SPIKE_FIFO_ISI_EN
      checks++;
      if (mi.size() != 0 && out_isi !== mi[0]) begin
        errors++;
        $display("FAIL random_isi[%0d] isi=%0d expected %0d", c, out_isi, mi[0]);
      end
`endif
    end
  endtask

`ifdef SPIKE_FIFO_ISI_EN
  task automatic test_isi();
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    repeat (10) tick();
    spike = 1'b1; tick(); spike = 1'b0;
    repeat (14) tick();
    spike = 1'b1; tick(); spike = 1'b0;
    checks++;
    if (out_isi !== 16'd10 || out_ts !== 16'd10) begin
      errors++;
      $display("FAIL isi_first isi=%0d ts=%0d expected 10/10", out_isi, out_ts);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (out_isi !== 16'd15 || out_ts !== 16'd25) begin
      errors++;
      $display("FAIL isi_second isi=%0d ts=%0d expected 15/25", out_isi, out_ts);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_held();
    test_overflow();
    test_full_pop();
    test_reset_mid();
`ifdef SPIKE_FIFO_ISI_EN
    test_isi();
`endif
    test_random();
    test_enable_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
